// File: rtl/biu_pkg.sv
// Shared definitions for the bus interface units: FSM encoding and bus control bit positions.
package biu_pkg;

  localparam int unsigned STATE_W = 5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 5'b00001,
    ST_SEND_REQ = 5'b00010,
    ST_WAIT_RSP = 5'b00100,
    ST_WAIT_REQ = 5'b01000,
    ST_BUS_ERR  = 5'b10000
  } state_t;

  localparam int unsigned BUS_CTRL_RNW   = 1;
  localparam int unsigned BUS_CTRL_VALID = 0;

endpackage

// File: rtl/biu_burst_master.sv
// Single-master burst bus interface unit: auto-incrementing bursts, per-beat read timeout,
// captured error address, shared tri-state address/data/control bus.
module biu_burst_master
  import biu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MAX_BURST      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned BURST_W        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] bus_address,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  inout  wire  [1:0]            bus_control,
  input  logic                  biu_en,
  input  logic [ADDR_WIDTH-1:0] biu_address,
  input  logic                  biu_rnw,
  input  logic [BURST_W-1:0]    biu_burst_len,
  input  logic [DATA_WIDTH-1:0] biu_data_out,
  output logic [DATA_WIDTH-1:0] biu_data_in,
  output logic                  biu_data_valid,
  output logic                  biu_data_last,
  output logic                  biu_wdata_req,
  output logic                  biu_busy,
  output logic                  biu_error,
  output logic [ADDR_WIDTH-1:0] biu_err_addr
);

  localparam int unsigned BYTES_PER_BEAT = DATA_WIDTH / 8;
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  rnw_q, rnw_d;
  logic [BURST_W-1:0]    beats_q, beats_d;
  logic [BURST_W-1:0]    beat_q, beat_d;
  logic [TO_W-1:0]       to_q, to_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  logic                  rsp_valid;
  logic                  last_beat;
  logic [ADDR_WIDTH-1:0] addr_inc;

  assign rsp_valid = bus_control[BUS_CTRL_VALID];
  assign last_beat = (beat_q == beats_q);
  assign addr_inc  = addr_q + ADDR_WIDTH'(BYTES_PER_BEAT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Transaction context registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      data_q     <= '0;
      rnw_q      <= 1'b0;
      beats_q    <= '0;
      beat_q     <= '0;
      to_q       <= '0;
      err_addr_q <= '0;
    end else begin
      addr_q     <= addr_d;
      data_q     <= data_d;
      rnw_q      <= rnw_d;
      beats_q    <= beats_d;
      beat_q     <= beat_d;
      to_q       <= to_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    data_d        = data_q;
    rnw_d         = rnw_q;
    beats_d       = beats_q;
    beat_d        = beat_q;
    to_d          = to_q;
    err_addr_d    = err_addr_q;
    biu_wdata_req = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (biu_en) begin
          addr_d  = biu_address;
          data_d  = biu_data_out;
          rnw_d   = biu_rnw;
          beats_d = (MAX_BURST > 1) ? biu_burst_len : '0;
          beat_d  = '0;
          state_d = ST_SEND_REQ;
        end
      end
      ST_SEND_REQ: begin
        to_d    = '0;
        state_d = rnw_q ? ST_WAIT_RSP : ST_WAIT_REQ;
      end
      ST_WAIT_RSP: begin
        // A response arriving on the final allowed cycle beats the timeout
        if (rsp_valid) begin
          if (last_beat) begin
            state_d = ST_IDLE;
          end else begin
            addr_d  = addr_inc;
            beat_d  = beat_q + BURST_W'(1);
            state_d = ST_SEND_REQ;
          end
        end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_BUS_ERR;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      ST_WAIT_REQ: begin
        if (last_beat) begin
          state_d = ST_IDLE;
        end else begin
          biu_wdata_req = 1'b1;
          data_d        = biu_data_out;
          addr_d        = addr_inc;
          beat_d        = beat_q + BURST_W'(1);
          state_d       = ST_SEND_REQ;
        end
      end
      ST_BUS_ERR: begin
        err_addr_d = addr_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign biu_busy       = (state_q != ST_IDLE);
  assign biu_error      = (state_q == ST_BUS_ERR);
  assign biu_err_addr   = err_addr_q;
  assign biu_data_valid = (state_q == ST_WAIT_RSP) && rsp_valid;
  assign biu_data_last  = biu_data_valid && last_beat;
  assign biu_data_in    = biu_data_valid ? bus_data : '0;

  // Bus is parked at zero when idle, driven while requesting, released otherwise
  assign bus_address = (state_q == ST_IDLE)     ? '0 :
                       (state_q == ST_SEND_REQ) ? addr_q : 'z;
  assign bus_data    = (state_q == ST_IDLE)     ? '0 :
                       (state_q == ST_SEND_REQ) ? data_q : 'z;
  assign bus_control = (state_q == ST_IDLE)     ? 2'b00 :
                       (state_q == ST_SEND_REQ) ? {rnw_q, 1'b1} : 2'bzz;

endmodule

// File: tb/tb_biu_burst_master.sv
// Directed self-checking bench for biu_burst_master with a hand-driven bus slave.
module tb_biu_burst_master;

  logic        clk;
  logic        rst;
  logic        biu_en;
  logic [31:0] biu_address;
  logic        biu_rnw;
  logic [2:0]  biu_burst_len;
  logic [31:0] biu_data_out;
  logic [31:0] biu_data_in;
  logic        biu_data_valid;
  logic        biu_data_last;
  logic        biu_wdata_req;
  logic        biu_busy;
  logic        biu_error;
  logic [31:0] biu_err_addr;

  wire  [31:0] bus_address;
  wire  [31:0] bus_data;
  wire  [1:0]  bus_control;

  logic        s_oe;
  logic        s_valid;
  logic [31:0] s_data;

  int passed = 0;
  int total  = 0;
  int req_cnt;

  assign bus_data    = s_oe ? s_data : 32'hzzzz_zzzz;
  assign bus_control = s_oe ? {1'b1, s_valid} : 2'bzz;

  biu_burst_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .MAX_BURST     (8),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus_address   (bus_address),
    .bus_data      (bus_data),
    .bus_control   (bus_control),
    .biu_en        (biu_en),
    .biu_address   (biu_address),
    .biu_rnw       (biu_rnw),
    .biu_burst_len (biu_burst_len),
    .biu_data_out  (biu_data_out),
    .biu_data_in   (biu_data_in),
    .biu_data_valid(biu_data_valid),
    .biu_data_last (biu_data_last),
    .biu_wdata_req (biu_wdata_req),
    .biu_busy      (biu_busy),
    .biu_error     (biu_error),
    .biu_err_addr  (biu_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; biu_en = 1'b0; biu_address = '0; biu_rnw = 1'b0;
    biu_burst_len = '0; biu_data_out = '0;
    s_oe = 1'b0; s_valid = 1'b0; s_data = '0;
    tick(); tick();
    settle();
    chk("rst_busy",     32'(biu_busy), 32'd0);
    chk("rst_valid",    32'(biu_data_valid), 32'd0);
    chk("rst_last",     32'(biu_data_last), 32'd0);
    chk("rst_wreq",     32'(biu_wdata_req), 32'd0);
    chk("rst_error",    32'(biu_error), 32'd0);
    chk("rst_err_addr", biu_err_addr, 32'd0);
    chk("rst_bus_addr", bus_address, 32'd0);
    chk("rst_bus_data", bus_data, 32'd0);
    chk("rst_bus_ctrl", 32'(bus_control), 32'd0);
    rst = 1'b0;
    tick();

    // Single read from 0x100
    biu_en = 1'b1; biu_address = 32'h100; biu_rnw = 1'b1; biu_burst_len = 3'd0;
    settle();
    chk("rd1_idle_busy", 32'(biu_busy), 32'd0);
    tick();
    biu_en = 1'b0;
    settle();
    chk("rd1_send_busy", 32'(biu_busy), 32'd1);
    chk("rd1_send_addr", bus_address, 32'h100);
    chk("rd1_send_ctrl", 32'(bus_control), 32'd3);
    tick();
    s_oe = 1'b1; s_valid = 1'b1; s_data = 32'hDEADBEEF;
    settle();
    chk("rd1_valid", 32'(biu_data_valid), 32'd1);
    chk("rd1_last",  32'(biu_data_last), 32'd1);
    chk("rd1_data",  biu_data_in, 32'hDEADBEEF);
    tick();
    s_oe = 1'b0; s_valid = 1'b0;
    settle();
    chk("rd1_done_busy",  32'(biu_busy), 32'd0);
    chk("rd1_done_valid", 32'(biu_data_valid), 32'd0);
    chk("rd1_done_data",  biu_data_in, 32'd0);
    chk("rd1_done_bus",   bus_address, 32'd0);

    // 4-beat write from 0x40, data 0xA..0xD
    biu_en = 1'b1; biu_address = 32'h40; biu_rnw = 1'b0; biu_burst_len = 3'd3;
    biu_data_out = 32'hA;
    req_cnt = 0;
    tick();
    biu_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      biu_data_out = 32'hA + 32'(i) + 32'd1;
      settle();
      chk("wr4_addr", bus_address, 32'h40 + 32'(4 * i));
      chk("wr4_data", bus_data, 32'hA + 32'(i));
      chk("wr4_ctrl", 32'(bus_control), 32'd1);
      chk("wr4_send_busy", 32'(biu_busy), 32'd1);
      tick();
      settle();
      chk("wr4_turn_busy", 32'(biu_busy), 32'd1);
      chk("wr4_wreq", 32'(biu_wdata_req), (i < 3) ? 32'd1 : 32'd0);
      if (biu_wdata_req) req_cnt++;
      tick();
    end
    settle();
    chk("wr4_req_count", 32'(req_cnt), 32'd3);
    chk("wr4_done_busy", 32'(biu_busy), 32'd0);

    // 4-beat read from 0x200, slave silent on beat 2 -> timeout
    biu_en = 1'b1; biu_address = 32'h200; biu_rnw = 1'b1; biu_burst_len = 3'd3;
    tick();
    biu_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("to_send_addr", bus_address, 32'h200 + 32'(4 * i));
      tick();
      s_oe = 1'b1; s_valid = 1'b1; s_data = 32'h11 * 32'(i + 1);
      settle();
      chk("to_valid", 32'(biu_data_valid), 32'd1);
      chk("to_last",  32'(biu_data_last), 32'd0);
      chk("to_data",  biu_data_in, 32'h11 * 32'(i + 1));
      tick();
      s_oe = 1'b0; s_valid = 1'b0;
    end
    settle();
    chk("to_send2_addr", bus_address, 32'h208);
    tick();
    s_oe = 1'b1; s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("to_wait_valid", 32'(biu_data_valid), 32'd0);
      chk("to_wait_error", 32'(biu_error), 32'd0);
      chk("to_wait_busy",  32'(biu_busy), 32'd1);
      tick();
    end
    s_oe = 1'b0;
    settle();
    chk("to_err_pulse", 32'(biu_error), 32'd1);
    chk("to_err_busy",  32'(biu_busy), 32'd1);
    tick();
    settle();
    chk("to_after_error", 32'(biu_error), 32'd0);
    chk("to_after_busy",  32'(biu_busy), 32'd0);
    chk("to_err_addr",    biu_err_addr, 32'h208);
    chk("to_no_beat3",    bus_address, 32'd0);
    tick();
    settle();
    chk("to_idle_busy", 32'(biu_busy), 32'd0);

    // Valid exactly on the 4th WAIT_RSP cycle is accepted
    biu_en = 1'b1; biu_address = 32'h300; biu_rnw = 1'b1; biu_burst_len = 3'd0;
    tick();
    biu_en = 1'b0;
    tick();
    s_oe = 1'b1; s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("edge_wait_valid", 32'(biu_data_valid), 32'd0);
      tick();
    end
    s_valid = 1'b1; s_data = 32'h5A5A5A5A;
    settle();
    chk("edge_valid", 32'(biu_data_valid), 32'd1);
    chk("edge_last",  32'(biu_data_last), 32'd1);
    chk("edge_data",  biu_data_in, 32'h5A5A5A5A);
    chk("edge_error", 32'(biu_error), 32'd0);
    tick();
    s_oe = 1'b0; s_valid = 1'b0;
    settle();
    chk("edge_done_busy",  32'(biu_busy), 32'd0);
    chk("edge_done_error", 32'(biu_error), 32'd0);
    chk("edge_err_hold",   biu_err_addr, 32'h208);

    // 2-beat write wrapping past the top of the address space
    biu_en = 1'b1; biu_address = 32'hFFFFFFFC; biu_rnw = 1'b0; biu_burst_len = 3'd1;
    biu_data_out = 32'h1;
    tick();
    biu_en = 1'b0; biu_data_out = 32'h2;
    settle();
    chk("wrap_addr0", bus_address, 32'hFFFFFFFC);
    chk("wrap_data0", bus_data, 32'h1);
    tick(); tick();
    settle();
    chk("wrap_addr1", bus_address, 32'h00000000);
    chk("wrap_data1", bus_data, 32'h2);
    tick(); tick();
    settle();
    chk("wrap_done_busy", 32'(biu_busy), 32'd0);

    // Reset in the middle of a 4-beat read
    biu_en = 1'b1; biu_address = 32'h500; biu_rnw = 1'b1; biu_burst_len = 3'd3;
    tick();
    biu_en = 1'b0;
    tick();
    s_oe = 1'b1; s_valid = 1'b1; s_data = 32'hCAFE0000;
    settle();
    chk("rr_beat0_valid", 32'(biu_data_valid), 32'd1);
    tick();
    s_oe = 1'b0; s_valid = 1'b0;
    settle();
    chk("rr_send1_addr", bus_address, 32'h504);
    tick();
    s_oe = 1'b1; s_valid = 1'b0; rst = 1'b1;
    settle();
    chk("rr_pre_busy", 32'(biu_busy), 32'd1);
    tick();
    s_oe = 1'b0; rst = 1'b0;
    settle();
    chk("rr_busy",     32'(biu_busy), 32'd0);
    chk("rr_valid",    32'(biu_data_valid), 32'd0);
    chk("rr_error",    32'(biu_error), 32'd0);
    chk("rr_err_addr", biu_err_addr, 32'd0);
    chk("rr_bus_addr", bus_address, 32'd0);
    chk("rr_bus_data", bus_data, 32'd0);
    chk("rr_bus_ctrl", 32'(bus_control), 32'd0);

    // Normal single read after the reset
    biu_en = 1'b1; biu_address = 32'h600; biu_rnw = 1'b1; biu_burst_len = 3'd0;
    tick();
    biu_en = 1'b0;
    settle();
    chk("post_send_addr", bus_address, 32'h600);
    tick();
    s_oe = 1'b1; s_valid = 1'b1; s_data = 32'h77;
    settle();
    chk("post_valid", 32'(biu_data_valid), 32'd1);
    chk("post_data",  biu_data_in, 32'h77);
    tick();
    s_oe = 1'b0; s_valid = 1'b0;
    settle();
    chk("post_done_busy", 32'(biu_busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
